// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two valid/ready requesters.
// Round-robin arbitration by default; define ALU_ARB_FIXED_PRIO_EN to give
// requester 0 fixed priority on ties.
// The ALU result is valid one edge after the operands, so each op walks
// IDLE (handshake) -> EXEC (ALU samples) -> RESP (result returned to owner).
// Request ready and the response bundle are decoded from registered state,
// so a requester sees ready in the same cycle it raises valid and a response
// in the cycle the ALU result appears.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
  output logic [WIDTH-1:0] alu_read1,
  output logic [WIDTH-1:0] alu_read2,
  output logic [OP_W-1:0]  alu_operation,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             last_grant, last_grant_nxt;
  logic [WIDTH-1:0] read1_nxt, read2_nxt;
  logic [OP_W-1:0]  op_nxt;
  logic             any_req;
  logic             grant;
  logic             result_zero;

  // Pick the winner: the sole valid requester, or the tie-break on contention
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else begin
      grant = req1_valid;
    end
  end

  // Next-state, register loads and handshake/response decode
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    read1_nxt      = alu_read1;
    read2_nxt      = alu_read2;
    op_nxt         = alu_operation;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    resp0_valid    = 1'b0;
    resp1_valid    = 1'b0;
    resp0_result   = '0;
    resp1_result   = '0;
    resp0_zero     = 1'b0;
    resp1_zero     = 1'b0;
    result_zero    = (alu_result == '0);

    case (state)
      IDLE: begin
        // ready is held low while reset is asserted even if valid is high
        if (any_req && !rst) begin
          req0_ready     = ~grant;
          req1_ready     = grant;
          owner_nxt      = grant;
          last_grant_nxt = grant;
          read1_nxt      = grant ? req1_a  : req0_a;
          read2_nxt      = grant ? req1_b  : req0_b;
          op_nxt         = grant ? req1_op : req0_op;
          state_nxt      = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (!owner) begin
          resp0_valid  = 1'b1;
          resp0_result = alu_result;
          resp0_zero   = result_zero;
          if (resp0_ready) state_nxt = IDLE;
        end else begin
          resp1_valid  = 1'b1;
          resp1_result = alu_result;
          resp1_zero   = result_zero;
          if (resp1_ready) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, ownership and ALU operand registers; reset drops any in-flight op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      alu_read1     <= '0;
      alu_read2     <= '0;
      alu_operation <= '0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      last_grant    <= last_grant_nxt;
      alu_read1     <= read1_nxt;
      alu_read2     <= read2_nxt;
      alu_operation <= op_nxt;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small registered ALU
// model. Honours ALU_ARB_FIXED_PRIO_EN for the tie-break expectations.
module tb_alu_arbiter;
  localparam int unsigned W    = 32;
  localparam int unsigned OP_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, resp_valid, resp_ready, resp_zero;
  logic [1:0][OP_W-1:0] req_op;
  logic [1:0][W-1:0] req_a, req_b, resp_result;
  logic [W-1:0] alu_read1, alu_read2, alu_result;
  logic [OP_W-1:0] alu_operation;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]),
    .resp0_valid(resp_valid[0]), .resp0_ready(resp_ready[0]),
    .resp0_result(resp_result[0]), .resp0_zero(resp_zero[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]),
    .resp1_valid(resp_valid[1]), .resp1_ready(resp_ready[1]),
    .resp1_result(resp_result[1]), .resp1_zero(resp_zero[1]),
    .alu_read1(alu_read1), .alu_read2(alu_read2),
    .alu_operation(alu_operation), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Registered ALU model: result one edge after operands; unknown ops give 0
  always_ff @(posedge clk) begin
    case (alu_operation)
      4'b0000: alu_result <= alu_read1 & alu_read2;
      4'b0001: alu_result <= alu_read1 | alu_read2;
      4'b0010: alu_result <= alu_read1 + alu_read2;
      4'b0110: alu_result <= alu_read1 - alu_read2;
      default: alu_result <= '0;
    endcase
  end

  typedef struct {
    int              who;
    logic [OP_W-1:0] op;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [W-1:0]    exp_res;
    logic            exp_zero;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One uncontended op from requester 'who', with cycle-exact timing checks
  task automatic do_op(input vec_t v);
    int o;
    logic [1:0] wb;
    o  = 1 - v.who;
    wb = 2'b01 << v.who;
    @(negedge clk);
    req_op[v.who] = v.op;
    req_a[v.who]  = v.a;
    req_b[v.who]  = v.b;
    req_valid     = wb;
    #1 chk("op_ready", 32'(req_ready), 32'(wb));
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("op_exec_no_resp", 32'(resp_valid), 32'd0);
    chk("op_exec_ready_low", 32'(req_ready), 32'd0);
    chk("op_alu_operation", 32'(alu_operation), 32'(v.op));
    chk("op_alu_read1", alu_read1, v.a);
    chk("op_alu_read2", alu_read2, v.b);
    @(negedge clk);
    #1 chk("op_resp_valid", 32'(resp_valid), 32'(wb));
    chk("op_resp_result", resp_result[v.who], v.exp_res);
    chk("op_resp_zero", 32'(resp_zero[v.who]), 32'(v.exp_zero));
    chk("op_other_result", resp_result[o], 32'd0);
    chk("op_other_zero", 32'(resp_zero[o]), 32'd0);
    resp_ready = wb;
    @(negedge clk);
    resp_ready = 2'b00;
    #1 chk("op_resp_done", 32'(resp_valid), 32'd0);
  endtask

  vec_t vecs[6];
  int   exp_order[4];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 2'b00;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;

    vecs[0] = '{0, 4'b0010, 32'd5,  32'd7,  32'd12,         1'b0};  // add
    vecs[1] = '{1, 4'b0110, 32'd9,  32'd9,  32'd0,          1'b1};  // sub to zero
    vecs[2] = '{0, 4'b1111, 32'd3,  32'd4,  32'd0,          1'b1};  // bad opcode
    vecs[3] = '{1, 4'b0000, 32'd12, 32'd10, 32'd8,          1'b0};  // and
    vecs[4] = '{0, 4'b0001, 32'd12, 32'd3,  32'd15,         1'b0};  // or
    vecs[5] = '{1, 4'b0110, 32'd3,  32'd5,  32'hFFFF_FFFE,  1'b0};  // wraps, no extension
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    // Reset values, with both requests valid during reset
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_alu_read1", alu_read1, 32'd0);
    chk("rst_alu_operation", 32'(alu_operation), 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    rst       = 1'b0;

    // Reset mid-EXEC discards the op
    @(negedge clk);
    req_op[0] = 4'b0010; req_a[0] = 32'd5; req_b[0] = 32'd6;
    req_valid = 2'b01;
    #1 chk("t1_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b11;
    #1 chk("t1_alu_read1_exec", alu_read1, 32'd5);
    rst = 1'b1;
    #1 chk("t1_alu_read1", alu_read1, 32'd0);
    chk("t1_alu_read2", alu_read2, 32'd0);
    chk("t1_alu_operation", 32'(alu_operation), 32'd0);
    chk("t1_ready_in_rst", 32'(req_ready), 32'd0);
    chk("t1_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t1_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    resp_ready = 2'b00;

    // Uncontended ops from the vector table
    for (int i = 0; i < 6; i++) do_op(vecs[i]);

    // Tie: both requesters held valid for four ops
    apply_reset();
    req_op[0] = 4'b0010; req_a[0] = 32'd1;  req_b[0] = 32'd2;
    req_op[1] = 4'b0110; req_a[1] = 32'd10; req_b[1] = 32'd4;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = -1;
      for (int c = 0; c < 8 && w < 0; c++) begin
        #1;
        if (req_ready == 2'b01) w = 0;
        else if (req_ready == 2'b10) w = 1;
        else if (req_ready == 2'b11) begin
          chk("t4_double_ready", 32'(req_ready), 32'd1);
          w = 0;
        end else @(negedge clk);
      end
      chk("t4_grant", 32'(w), 32'(exp_order[k]));
      if (w >= 0) begin
        @(negedge clk);
        #1 chk("t4_exec_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1 chk("t4_resp_valid", 32'(resp_valid), 32'(2'b01 << w));
        chk("t4_resp_result", resp_result[w], (w == 0) ? 32'd3 : 32'd6);
        chk("t4_resp_ready_low", 32'(req_ready), 32'd0);
      end
    end
    req_valid  = 2'b00;
    resp_ready = 2'b00;

    // Backpressure: response held, pending requester waits
    apply_reset();
    req_op[0] = 4'b0010; req_a[0] = 32'd20; req_b[0] = 32'd22;
    req_op[1] = 4'b0010; req_a[1] = 32'd1;  req_b[1] = 32'd1;
    req_valid = 2'b11;
    #1 chk("t5_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1 chk("t5_exec_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1 chk("t5_hold_valid", 32'(resp_valid), 32'd1);
      chk("t5_hold_result", resp_result[0], 32'd42);
      chk("t5_hold_ready", 32'(req_ready), 32'd0);
      chk("t5_other_result", resp_result[1], 32'd0);
      @(negedge clk);
    end
    resp_ready[0] = 1'b1;
    #1 chk("t5_ack_valid", 32'(resp_valid), 32'd1);
    chk("t5_ack_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    resp_ready[0] = 1'b0;
    #1 chk("t5_req1_ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    #1 chk("t5_resp1_valid", 32'(resp_valid), 32'd2);
    chk("t5_resp1_result", resp_result[1], 32'd2);
    resp_ready[1] = 1'b1;
    @(negedge clk);
    resp_ready[1] = 1'b0;
    #1 chk("t5_done", 32'(resp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
